// File: rtl/ir_led_ctrl_pkg.sv
// Shared types and helpers for the IR LED pad sequencer.
// The soft-start mask is used only when IR_SOFT_START_EN is defined.
package ir_led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2,
        ST_END   = 2'd3
    } ir_state_e;

    localparam int IR_DRV_W = 10;

    // Mask enabling the low k+1 sink bits; saturates to all ones for large k.
    function automatic logic [31:0] soft_mask(input logic [15:0] k);
        if (k >= 16'd31) begin
            soft_mask = '1;
        end else begin
            soft_mask = (32'd1 << (k + 16'd1)) - 32'd1;
        end
    endfunction

endpackage

// File: rtl/ir_led_ctrl_carrier.sv
// Carrier phase counter: wraps 0..P-1 (P=0 behaves as P=1), flags the last
// phase of each period and predicts the high/low level for the next cycle.
module ir_carrier_gen #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [CNT_W-1:0] high_i,
    output logic             strobe_o,
    output logic             hi_next_o
);

    logic [CNT_W-1:0] phase_q;
    logic [CNT_W-1:0] phase_d;
    logic [CNT_W-1:0] last_phase;

    always_comb begin
        last_phase = (period_i == '0) ? '0 : period_i - CNT_W'(1);
        strobe_o   = en_i && (phase_q == last_phase);
        phase_d    = phase_q;
        if (clr_i) begin
            phase_d = '0;
        end else if (en_i) begin
            phase_d = strobe_o ? '0 : phase_q + CNT_W'(1);
        end
        // Registered ir_pwm is derived from the phase the next cycle will show.
        hi_next_o = (phase_d < high_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/ir_led_ctrl.sv
// IR LED current-sink sequencer: mark/space burst trains on ir_pwm/cbit_ir.
// Optional build macro IR_SOFT_START_EN ramps cbit_ir during each mark.
module ir_led_ctrl
    import ir_led_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 12,
    parameter int RPT_W   = 8,
    parameter int DRV_W   = IR_DRV_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               poc,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [CNT_W-1:0]   cfg_high,
    input  logic [BURST_W-1:0] cfg_mark,
    input  logic [BURST_W-1:0] cfg_space,
    input  logic [RPT_W-1:0]   cfg_repeat,
    input  logic [DRV_W-1:0]   cfg_drive,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic               ir_pwm,
    output logic [DRV_W-1:0]   cbit_ir
);

    ir_state_e state_q, state_d;
    logic [BURST_W-1:0] cnt_q, cnt_d;
    logic [RPT_W-1:0]   rpt_q, rpt_d;
    logic               abort_d;

    logic [CNT_W-1:0]   period_q, high_q;
    logic [BURST_W-1:0] mark_q, space_q;
    logic [RPT_W-1:0]   repeat_q;
    logic [DRV_W-1:0]   drive_q;

    logic [CNT_W-1:0]   period_e, high_e;
    logic [BURST_W-1:0] mark_e, space_e;
    logic [RPT_W-1:0]   repeat_e;
    logic [DRV_W-1:0]   drive_e;

    logic idle, running, strobe, hi_next;
    logic active_d, pwm_d;
    logic [DRV_W-1:0] drive_d, cbit_d;

    logic busy_q, done_q, aborted_q, pwm_q;
    logic [DRV_W-1:0] cbit_q;

    assign idle    = (state_q == ST_IDLE);
    assign running = (state_q == ST_MARK) || (state_q == ST_SPACE);

    // While idle the live config drives decisions so the first train cycle
    // already reflects it; afterwards only the snapshot taken at start counts.
    assign period_e = idle ? cfg_period : period_q;
    assign high_e   = idle ? cfg_high   : high_q;
    assign mark_e   = idle ? cfg_mark   : mark_q;
    assign space_e  = idle ? cfg_space  : space_q;
    assign repeat_e = idle ? cfg_repeat : repeat_q;
    assign drive_e  = idle ? cfg_drive  : drive_q;

    always_ff @(posedge clk) begin
        if (idle) begin
            period_q <= cfg_period;
            high_q   <= cfg_high;
            mark_q   <= cfg_mark;
            space_q  <= cfg_space;
            repeat_q <= cfg_repeat;
            drive_q  <= cfg_drive;
        end
    end

    ir_carrier_gen #(
        .CNT_W (CNT_W)
    ) u_carrier (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (running),
        .clr_i     (!running),
        .period_i  (period_e),
        .high_i    (high_e),
        .strobe_o  (strobe),
        .hi_next_o (hi_next)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rpt_d   = rpt_q;
        abort_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                rpt_d = '0;
                if (start && !poc) begin
                    state_d = (mark_e == '0) ? ST_END : ST_MARK;
                end
            end
            ST_MARK: begin
                if (poc || stop) begin
                    state_d = ST_END;
                    abort_d = 1'b1;
                end else if (strobe) begin
                    if ((cnt_q + BURST_W'(1)) == mark_e) begin
                        cnt_d = '0;
                        if (space_e != '0) begin
                            state_d = ST_SPACE;
                        end else if (rpt_q == repeat_e) begin
                            state_d = ST_END;
                        end else begin
                            rpt_d = rpt_q + RPT_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + BURST_W'(1);
                    end
                end
            end
            ST_SPACE: begin
                if (poc || stop) begin
                    state_d = ST_END;
                    abort_d = 1'b1;
                end else if (strobe) begin
                    if ((cnt_q + BURST_W'(1)) == space_e) begin
                        cnt_d = '0;
                        if (rpt_q == repeat_e) begin
                            state_d = ST_END;
                        end else begin
                            state_d = ST_MARK;
                            rpt_d   = rpt_q + RPT_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + BURST_W'(1);
                    end
                end
            end
            ST_END: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                rpt_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        active_d = (state_d == ST_MARK) || (state_d == ST_SPACE);
        pwm_d    = (state_d == ST_MARK) && hi_next;
`ifdef IR_SOFT_START_EN
        // cnt_d is the index of the carrier period the next mark cycle is in.
        drive_d  = (state_d == ST_MARK) ?
                   (drive_e & DRV_W'(soft_mask(16'(cnt_d)))) : drive_e;
`else
        drive_d  = drive_e;
`endif
        cbit_d   = active_d ? drive_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rpt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            pwm_q     <= 1'b0;
            cbit_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rpt_q     <= rpt_d;
            busy_q    <= active_d;
            done_q    <= (state_d == ST_END);
            aborted_q <= abort_d;
            pwm_q     <= pwm_d;
            cbit_q    <= cbit_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;
    assign ir_pwm  = pwm_q;
    assign cbit_ir = cbit_q;

endmodule
